vga_timing_pipe: RTL

Upstream raster timing stage for the glyph-mode VGA designs. It generates 640x480@60 (25.175 MHz pixel clock) counters, sync and blanking signals. It also provides a frame counter clocked in the pixel domain, which removes the need for logic clocked on a vsync edge, and line/frame start strobes. A configurable delay line realigns sync/blank with the downstream glyph/palette pipeline before the signals reach the TinyVGA PMOD pins.

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/sync_delay_line.sv | 31 +++
 rtl/vga_timing_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for the 640x480@60 timing stage.
// Default parameter values and small helpers used to derive sync windows.
package vga_timing_pkg;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam bit          DEF_SYNC_ACTIVE_HIGH = 1'b0;
  localparam int unsigned DEF_PIPE_DELAY       = 2;
  localparam int unsigned DEF_FRAME_W          = 10;

  localparam int unsigned POS_W = 10;

  typedef logic [POS_W-1:0] pos_t;

  function automatic int unsigned span_total(input int unsigned disp, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return disp + front + sync + back;
  endfunction

  function automatic int unsigned sync_first(input int unsigned disp, input int unsigned front);
    return disp + front;
  endfunction

  function automatic int unsigned sync_last(input int unsigned disp, input int unsigned front,
                                            input int unsigned sync);
    return disp + front + sync - 1;
  endfunction

  // Map a logical "in sync window" flag onto the configured pin polarity.
  function automatic logic sync_level(input logic active, input bit active_high);
    return active ? active_high : !active_high;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Parameterized shift register with asynchronous reset to a fixed pattern.
// DEPTH=0 degenerates to a wire; also used for the downstream colour path.
module sync_delay_line #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_passthru
    assign data_o = data_i;
  end else begin : g_stages
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else begin
        stage_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// Raster timing generator: counters, syncs, blanking, strobes and a pixel-domain
// frame counter, plus a delay line realigning sync/blank with the colour pipeline.
module vga_timing_pipe
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY        = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT          = DEF_H_FRONT,
  parameter int unsigned H_SYNC           = DEF_H_SYNC,
  parameter int unsigned H_BACK           = DEF_H_BACK,
  parameter int unsigned V_DISPLAY        = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT          = DEF_V_FRONT,
  parameter int unsigned V_SYNC           = DEF_V_SYNC,
  parameter int unsigned V_BACK           = DEF_V_BACK,
  parameter bit          SYNC_ACTIVE_HIGH = DEF_SYNC_ACTIVE_HIGH,
  parameter int unsigned PIPE_DELAY       = DEF_PIPE_DELAY,
  parameter int unsigned FRAME_W          = DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_wrapped,
  output logic               hsync_d,
  output logic               vsync_d,
  output logic               display_on_d
);

  localparam int unsigned H_TOTAL = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_pipe: H_TOTAL and V_TOTAL must each be <= 1024");
  end
  if (PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_pipe: PIPE_DELAY must be <= 7");
  end

  localparam pos_t H_LAST      = POS_W'(H_TOTAL - 1);
  localparam pos_t V_LAST      = POS_W'(V_TOTAL - 1);
  localparam pos_t H_VISIBLE   = POS_W'(H_DISPLAY);
  localparam pos_t V_VISIBLE   = POS_W'(V_DISPLAY);
  localparam pos_t HSYNC_START = POS_W'(sync_first(H_DISPLAY, H_FRONT));
  localparam pos_t HSYNC_END   = POS_W'(sync_last(H_DISPLAY, H_FRONT, H_SYNC));
  localparam pos_t VSYNC_START = POS_W'(sync_first(V_DISPLAY, V_FRONT));
  localparam pos_t VSYNC_END   = POS_W'(sync_last(V_DISPLAY, V_FRONT, V_SYNC));
  localparam logic SYNC_IDLE   = !SYNC_ACTIVE_HIGH;

  pos_t               hpos_q, hpos_d, vpos_q, vpos_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic               ls_q, ls_d, fs_q, fs_d, wrap_q, wrap_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [2:0]         delayed;

  // Decode everything from the next-state counters so it lines up with hpos/vpos.
  always_comb begin
    hpos_d = (hpos_q == H_LAST) ? '0 : hpos_q + POS_W'(1);
    vpos_d = vpos_q;
    if (hpos_q == H_LAST) vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + POS_W'(1);
    hs_d    = sync_level((hpos_d >= HSYNC_START) && (hpos_d <= HSYNC_END), SYNC_ACTIVE_HIGH);
    vs_d    = sync_level((vpos_d >= VSYNC_START) && (vpos_d <= VSYNC_END), SYNC_ACTIVE_HIGH);
    de_d    = (hpos_d < H_VISIBLE) && (vpos_d < V_VISIBLE);
    ls_d    = (hpos_d == '0);
    fs_d    = ls_d && (vpos_d == '0);
    frame_d = fs_d ? frame_q + FRAME_W'(1) : frame_q;
    wrap_d  = wrap_q || (fs_d && (&frame_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hs_q    <= SYNC_IDLE;
      vs_q    <= SYNC_IDLE;
      de_q    <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      frame_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      frame_q <= frame_d;
      wrap_q  <= wrap_d;
    end
  end

  sync_delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL({SYNC_IDLE, SYNC_IDLE, 1'b0})
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .data_i({hs_q, vs_q, de_q}),
    .data_o(delayed)
  );

  assign hpos          = hpos_q;
  assign vpos          = vpos_q;
  assign hsync         = hs_q;
  assign vsync         = vs_q;
  assign display_on    = de_q;
  assign line_start    = ls_q;
  assign frame_start   = fs_q;
  assign frame         = frame_q;
  assign frame_wrapped = wrap_q;
  assign hsync_d       = delayed[2];
  assign vsync_d       = delayed[1];
  assign display_on_d  = delayed[0];

endmodule
